// File: rtl/cpu_pkg.sv
// Shared fetch-side types: word type, fetch FSM states, and the instruction payload to decode.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  // Exactly one memory request is ever outstanding; DROP waits out a squashed response.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // Instruction handed to decode together with its address.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } if_payload_t;

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational redirect target from the branch unit's resolution.
//   i_br_valid   : decode holds a valid instruction (qualifies jmp/branch)
//   i_br_pc      : PC of the instruction in decode
//   i_jmp        : unconditional jump resolved (wins over branch)
//   i_branch     : conditional branch resolved taken
//   i_offset     : branch word offset, [15:0] used, sign in bit 15
//   i_target     : jump word index, [25:0] used
//   o_redirect_c : fetch must be redirected this cycle
//   o_npc_c      : redirect target address
module npc_calc
  import cpu_pkg::*;
(
  input  logic  i_br_valid,
  input  word_t i_br_pc,
  input  logic  i_jmp,
  input  logic  i_branch,
  input  word_t i_offset,
  input  word_t i_target,
  output logic  o_redirect_c,
  output word_t o_npc_c
);

  word_t w_br_pc_p4;
  word_t w_br_off;
  word_t w_jmp_tgt;
  logic  w_unused_bits;

  // Both target forms are relative to the instruction after the one in decode.
  assign w_br_pc_p4 = i_br_pc + XLEN'(INSTR_BYTES);
  assign w_br_off   = {{14{i_offset[15]}}, i_offset[15:0], 2'b00};
  assign w_jmp_tgt  = {w_br_pc_p4[31:28], i_target[25:0], 2'b00};

  assign o_redirect_c = i_br_valid & (i_jmp | i_branch);
  assign o_npc_c      = i_jmp ? w_jmp_tgt : (w_br_pc_p4 + w_br_off);

  // Upper bits of offset/target carry no meaning here.
  assign w_unused_bits = &{1'b0, i_offset[31:16], i_target[31:26]};

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetch, with squash on redirect.
//   clk, rst_n        : clock, asynchronous active-low reset
//   br_valid, br_pc   : decode-side qualifier and PC for the branch resolution
//   jmp, branch       : resolved jump / taken branch (jump wins)
//   offset, target    : branch offset [15:0] / jump index [25:0]
//   imem_req/addr     : fetch request (registered) and address (= pc register)
//   imem_gnt          : request accepted
//   imem_rvalid/rdata : response, one per granted request
//   if_valid/instr/pc : instruction to decode, held until id_ready
//   id_ready          : decode accepts the instruction
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        jmp,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  word_t        r_pc;
  word_t        w_pc_nxt;
  word_t        r_req_pc;
  word_t        w_req_pc_nxt;
  logic         r_imem_req;
  logic         r_if_valid;
  logic         w_if_valid_nxt;
  if_payload_t  r_if;
  if_payload_t  w_if_nxt;
  logic         w_redirect;
  word_t        w_npc;
  logic         w_gnt;

  npc_calc u_npc_calc (
    .i_br_valid   (br_valid),
    .i_br_pc      (br_pc),
    .i_jmp        (jmp),
    .i_branch     (branch),
    .i_offset     (offset),
    .i_target     (target),
    .o_redirect_c (w_redirect),
    .o_npc_c      (w_npc)
  );

  // A grant only counts while the request is actually on the bus (not the first cycle after reset).
  assign w_gnt = r_imem_req & imem_gnt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_imem_req <= 1'b0;
      r_if_valid <= 1'b0;
      r_if       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_imem_req <= (w_state_nxt == REQ);
      r_if_valid <= w_if_valid_nxt;
      r_if       <= w_if_nxt;
    end
  end

  // Next-state and datapath updates; redirect is applied last so it overrides the normal path.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_pc_nxt   = r_req_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_nxt       = r_if;

    unique case (r_state)
      REQ: begin
        if (w_gnt) begin
          w_req_pc_nxt = r_pc;
          w_state_nxt  = w_redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (w_redirect) begin
            w_state_nxt = REQ;
          end else begin
            w_state_nxt    = HOLD;
            w_if_nxt.instr = imem_rdata;
            w_if_nxt.pc    = r_req_pc;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = r_req_pc + XLEN'(INSTR_BYTES);
          end
        end else if (w_redirect) begin
          w_state_nxt = DROP;
        end
      end
      HOLD: begin
        if (id_ready || w_redirect) begin
          w_state_nxt    = REQ;
          w_if_valid_nxt = 1'b0;
        end
      end
      DROP: begin
        // The squashed response retires here; a redirect only moves pc.
        if (imem_rvalid) begin
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = REQ;
      end
    endcase

    if (w_redirect) begin
      w_pc_nxt       = w_npc;
      w_if_valid_nxt = 1'b0;
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if.instr;
  assign if_pc     = r_if.pc;

`ifndef SYNTHESIS
  // A response with no request outstanding means the memory broke the handshake.
  a_rvalid_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_state == WAIT || r_state == DROP));
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, redirects in every state, async reset.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        jmp;
  logic        branch;
  logic [31:0] offset;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_valid    (br_valid),
    .br_pc       (br_pc),
    .jmp         (jmp),
    .branch      (branch),
    .offset      (offset),
    .target      (target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of branch-unit resolution, then quiet.
  task automatic redir(input logic j, input logic b, input logic [31:0] pc,
                       input logic [31:0] off, input logic [31:0] tgt);
    br_valid = 1'b1; jmp = j; branch = b; br_pc = pc; offset = off; target = tgt;
    tick();
    br_valid = 1'b0; jmp = 1'b0; branch = 1'b0;
  endtask

  // Full fetch from REQ at pc: gnt, rvalid next cycle, decode accepts.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] word);
    chk("req_addr", imem_addr, pc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req_low", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = word;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_valid", 32'(if_valid), 32'd1);
    chk("hold_pc", if_pc, pc);
    chk("hold_instr", if_instr, word);
    chk("hold_req_low", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("next_valid_low", 32'(if_valid), 32'd0);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, pc + 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_pc = '0; jmp = 1'b0; branch = 1'b0;
    offset = '0; target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);

    // 1: sequential fetch 0x0, 0x4, 0x8
    fetch_one(32'h0, 32'h1111_0000);
    fetch_one(32'h4, 32'h1111_0001);
    fetch_one(32'h8, 32'h1111_0002);

    // Unqualified resolution is ignored
    br_valid = 1'b0; jmp = 1'b1; br_pc = 32'h500; target = 32'h7;
    tick();
    jmp = 1'b0;
    chk("no_brvalid_addr", imem_addr, 32'hC);

    // 2: backward branch -1 and forward branch +3 while in REQ without gnt
    redir(1'b0, 1'b1, 32'h100, 32'h0000_FFFF, 32'h0);
    chk("br_neg_addr", imem_addr, 32'h100);
    chk("br_neg_req", 32'(imem_req), 32'd1);
    redir(1'b0, 1'b1, 32'h100, 32'h0000_0003, 32'h0);
    chk("br_pos_addr", imem_addr, 32'h110);

    // 3: jump keeps upper nibble of br_pc+4; jump wins over branch
    redir(1'b1, 1'b0, 32'hA000_0010, 32'h0, 32'h0000_0040);
    chk("jmp_addr", imem_addr, 32'hA000_0100);
    redir(1'b1, 1'b1, 32'h100, 32'h0000_0003, 32'h0000_0040);
    chk("jmp_wins_addr", imem_addr, 32'h100);

    // 4: redirect in WAIT, response held off 3 cycles
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redir(1'b0, 1'b1, 32'h200, 32'h0000_0001, 32'h0);
    chk("wait_redir_state", 32'(dut.r_state), 32'(DROP));
    chk("wait_redir_addr", imem_addr, 32'h208);
    chk("drop_req_low0", 32'(imem_req), 32'd0);
    tick();
    chk("drop_req_low1", 32'(imem_req), 32'd0);
    tick();
    chk("drop_req_low2", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_done_req", 32'(imem_req), 32'd1);
    chk("drop_done_valid", 32'(if_valid), 32'd0);
    chk("drop_done_instr", if_instr, 32'h1111_0002);
    fetch_one(32'h208, 32'h2222_2222);

    // 5a: redirect in the same cycle as gnt
    imem_gnt = 1'b1;
    redir(1'b1, 1'b0, 32'h300, 32'h0, 32'h0000_0080);
    imem_gnt = 1'b0;
    chk("gnt_redir_state", 32'(dut.r_state), 32'(DROP));
    chk("gnt_redir_addr", imem_addr, 32'h200);
    tick();
    chk("gnt_redir_no_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0;
    chk("gnt_redir_req", 32'(imem_req), 32'd1);
    chk("gnt_redir_instr", if_instr, 32'h2222_2222);
    fetch_one(32'h200, 32'h3333_3333);

    // 5b: redirect in the same cycle as rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    redir(1'b0, 1'b1, 32'h400, 32'h0, 32'h0);
    imem_rvalid = 1'b0;
    chk("rv_redir_req", 32'(imem_req), 32'd1);
    chk("rv_redir_addr", imem_addr, 32'h404);
    chk("rv_redir_valid", 32'(if_valid), 32'd0);
    chk("rv_redir_instr", if_instr, 32'h3333_3333);
    fetch_one(32'h404, 32'h4444_4444);

    // Redirect in HOLD beats the id_ready handshake
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    imem_rvalid = 1'b0;
    chk("hold2_valid", 32'(if_valid), 32'd1);
    id_ready = 1'b1;
    redir(1'b1, 1'b0, 32'h1000, 32'h0, 32'h0000_0010);
    id_ready = 1'b0;
    chk("hold_redir_valid", 32'(if_valid), 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h40);
    chk("hold_redir_req", 32'(imem_req), 32'd1);

    // 6: async reset mid-WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_restart_req", 32'(imem_req), 32'd1);
    fetch_one(32'h0, 32'h6666_6666);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
